// File: rtl/cnn_host_loader_if.sv
// Host byte stream: 8-bit command/payload bytes with valid/ready handshake.
// Latency: wires only, no storage.
// Backpressure: a byte transfers on a rising edge where s_valid && s_ready.
//
// Signals: s_data (byte), s_valid (source has a byte), s_ready (sink accepts).
// Modports: master = host side that drives bytes, slave = loader side.
interface cnn_host_loader_if;
  logic [7:0] s_data;
  logic       s_valid;
  logic       s_ready;

  modport master (output s_data, output s_valid, input s_ready);
  modport slave  (input s_data, input s_valid, output s_ready);
endinterface

// File: rtl/cnn_host_loader.sv
// Stream-to-parallel loader: assembles kernels, FC weights and the image for the CNN core.
// Latency: write strobe / start pulse low for one cycle, one cycle after the last byte is accepted.
// Backpressure: s_ready low during COMMIT/START_PULSE, and in IDLE for IMG/START while cnn_busy.
//
// Ports:
//   clk, rst                      clock and synchronous active-high reset
//   host (slave)                  command/payload byte stream
//   cnn_busy                      CNN is not idle
//   image_input                   2-bit signed image, [row][col]
//   feature_weights_input         2-bit signed kernel, row-major
//   feature_writeAddr             kernel slot for feature_WrEn
//   feature_WrEn                  active-low kernel write strobe
//   fullyconnected_weights_input  FC weights
//   fullyconnected_WrEn           active-low FC write strobe
//   convolution_enable            active-low start pulse
//   ready_to_start                every kernel, the FC weights and the image are loaded
//   cmd_error                     sticky protocol error
module cnn_host_loader #(
  parameter int IMAGE_WIDTH               = 12,
  parameter int IMAGE_HEIGHT              = 12,
  parameter int NUM_FEATURES              = 2,
  parameter int KERNEL_SIZE               = 3,
  parameter int FLATTENED_LENGTH          = 50,
  parameter int FULLYCONNECTED_DATA_WIDTH = 8
) (
  input  logic                                 clk,
  input  logic                                 rst,
  cnn_host_loader_if.slave                     host,
  input  logic                                 cnn_busy,
  output logic signed [1:0]                    image_input [IMAGE_HEIGHT][IMAGE_WIDTH],
  output logic signed [1:0]                    feature_weights_input [KERNEL_SIZE*KERNEL_SIZE],
  output logic [$clog2(NUM_FEATURES):0]        feature_writeAddr,
  output logic                                 feature_WrEn,
  output logic [FULLYCONNECTED_DATA_WIDTH-1:0] fullyconnected_weights_input [FLATTENED_LENGTH],
  output logic                                 fullyconnected_WrEn,
  output logic                                 convolution_enable,
  output logic                                 ready_to_start,
  output logic                                 cmd_error
);

  localparam logic [7:0] CMD_FEAT  = 8'h01;
  localparam logic [7:0] CMD_FC    = 8'h02;
  localparam logic [7:0] CMD_IMG   = 8'h03;
  localparam logic [7:0] CMD_START = 8'h04;

  localparam int KK         = KERNEL_SIZE * KERNEL_SIZE;
  localparam int MAX_LEN    = (KK > FLATTENED_LENGTH) ? KK : FLATTENED_LENGTH;
  localparam int IDX_W      = $clog2(MAX_LEN + 1);
  localparam int ROW_W      = $clog2(IMAGE_HEIGHT + 1);
  localparam int COL_W      = $clog2(IMAGE_WIDTH + 1);
  localparam int FA_W       = $clog2(NUM_FEATURES) + 1;
  localparam logic [7:0] NUM_FEAT_B = 8'(NUM_FEATURES);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FEAT_ADDR,
    ST_FEAT_DATA,
    ST_FC_DATA,
    ST_IMG_DATA,
    ST_COMMIT,
    ST_START_PULSE
  } state_t;

  typedef enum logic [1:0] {K_FEAT, K_FC, K_IMG} kind_t;

  state_t                  state;
  kind_t                   kind;
  logic [IDX_W-1:0]        idx;
  logic [ROW_W-1:0]        row;
  logic [COL_W-1:0]        col;
  logic                    slot_bad;
  logic [NUM_FEATURES-1:0] feat_loaded;
  logic                    fc_loaded;
  logic                    image_loaded;
  logic                    accept;

  // In IDLE, IMG and START must not reach a running CNN, so they stall on the
  // byte itself; FEAT and FC only fill staging registers and go straight through.
  always_comb begin
    host.s_ready = 1'b0;
    if (!rst) begin
      case (state)
        ST_IDLE:
          host.s_ready = !(host.s_valid && cnn_busy &&
                           (host.s_data == CMD_IMG || host.s_data == CMD_START));
        ST_FEAT_ADDR, ST_FEAT_DATA, ST_FC_DATA, ST_IMG_DATA:
          host.s_ready = 1'b1;
        default:
          host.s_ready = 1'b0;
      endcase
    end
  end

  assign accept         = host.s_valid && host.s_ready;
  assign ready_to_start = (&feat_loaded) & fc_loaded & image_loaded;

  always_ff @(posedge clk) begin
    if (rst) begin
      state               <= ST_IDLE;
      kind                <= K_IMG;
      idx                 <= '0;
      row                 <= '0;
      col                 <= '0;
      slot_bad            <= 1'b0;
      feature_writeAddr   <= '0;
      feature_WrEn        <= 1'b1;
      fullyconnected_WrEn <= 1'b1;
      convolution_enable  <= 1'b1;
      feat_loaded         <= '0;
      fc_loaded           <= 1'b0;
      image_loaded        <= 1'b0;
      cmd_error           <= 1'b0;
      for (int r = 0; r < IMAGE_HEIGHT; r++)
        for (int c = 0; c < IMAGE_WIDTH; c++)
          image_input[r][c] <= '0;
      for (int i = 0; i < KK; i++)
        feature_weights_input[i] <= '0;
      for (int i = 0; i < FLATTENED_LENGTH; i++)
        fullyconnected_weights_input[i] <= '0;
    end else begin
      // Strobes are single-cycle: default high, pulled low only by COMMIT/START_PULSE.
      feature_WrEn        <= 1'b1;
      fullyconnected_WrEn <= 1'b1;
      convolution_enable  <= 1'b1;

      case (state)
        ST_IDLE: begin
          if (accept) begin
            idx <= '0;
            row <= '0;
            col <= '0;
            case (host.s_data)
              CMD_FEAT: begin
                kind  <= K_FEAT;
                state <= ST_FEAT_ADDR;
              end
              CMD_FC: begin
                kind  <= K_FC;
                state <= ST_FC_DATA;
              end
              CMD_IMG: begin
                kind  <= K_IMG;
                state <= ST_IMG_DATA;
              end
              CMD_START: begin
                if (ready_to_start) state <= ST_START_PULSE;
                else                cmd_error <= 1'b1;
              end
              default: cmd_error <= 1'b1;
            endcase
          end
        end

        ST_FEAT_ADDR: begin
          if (accept) begin
            // An out-of-range slot still consumes its payload so the stream
            // stays framed, but leaves the CNN-facing kernel state untouched.
            if (host.s_data < NUM_FEAT_B) begin
              feature_writeAddr <= FA_W'(host.s_data);
              slot_bad          <= 1'b0;
            end else begin
              slot_bad  <= 1'b1;
              cmd_error <= 1'b1;
            end
            state <= ST_FEAT_DATA;
          end
        end

        ST_FEAT_DATA: begin
          if (accept) begin
            if (!slot_bad)
              for (int i = 0; i < KK; i++)
                if (idx == IDX_W'(i)) feature_weights_input[i] <= host.s_data[1:0];
            if (idx == IDX_W'(KK - 1)) state <= ST_COMMIT;
            else                       idx   <= idx + 1'b1;
          end
        end

        ST_FC_DATA: begin
          if (accept) begin
            for (int i = 0; i < FLATTENED_LENGTH; i++)
              if (idx == IDX_W'(i))
                fullyconnected_weights_input[i] <= FULLYCONNECTED_DATA_WIDTH'(host.s_data);
            if (idx == IDX_W'(FLATTENED_LENGTH - 1)) state <= ST_COMMIT;
            else                                     idx   <= idx + 1'b1;
          end
        end

        ST_IMG_DATA: begin
          if (accept) begin
            for (int r = 0; r < IMAGE_HEIGHT; r++)
              for (int c = 0; c < IMAGE_WIDTH; c++)
                if (row == ROW_W'(r) && col == COL_W'(c))
                  image_input[r][c] <= host.s_data[1:0];
            if (col == COL_W'(IMAGE_WIDTH - 1)) begin
              col <= '0;
              if (row == ROW_W'(IMAGE_HEIGHT - 1)) state <= ST_COMMIT;
              else                                 row   <= row + 1'b1;
            end else begin
              col <= col + 1'b1;
            end
          end
        end

        ST_COMMIT: begin
          case (kind)
            K_FEAT: begin
              if (!slot_bad) begin
                feature_WrEn <= 1'b0;
                for (int i = 0; i < NUM_FEATURES; i++)
                  if (feature_writeAddr == FA_W'(i)) feat_loaded[i] <= 1'b1;
              end
            end
            K_FC: begin
              fullyconnected_WrEn <= 1'b0;
              fc_loaded           <= 1'b1;
            end
            default: image_loaded <= 1'b1;
          endcase
          state <= ST_IDLE;
        end

        ST_START_PULSE: begin
          convolution_enable <= 1'b0;
          state              <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
